// File: rtl/rule_port_filter.sv
// Rule-to-port-group filter: ROM slot fetch, range-table check, buffered output of matching rules.
// Optional counters enabled by defining RULE_PORT_FILTER_STATS_EN.
module rule_port_filter #(
  parameter int unsigned RULE_AWIDTH = 16,
  parameter int unsigned NUM_PG      = 4,
  parameter int unsigned PG_AWIDTH   = 9,
  parameter int unsigned RULE_RD_LAT = 2,
  parameter int unsigned FIFO_DEPTH  = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [RULE_AWIDTH-1:0]        in_rule,
  input  logic [15:0]                   in_src_port,
  input  logic [15:0]                   in_dst_port,
  input  logic                          in_tcp,
  output logic [RULE_AWIDTH-1:0]        r2pg_addr,
  input  logic [NUM_PG*PG_AWIDTH-1:0]   r2pg_data,
  input  logic                          cfg_wr,
  input  logic [PG_AWIDTH-1:0]          cfg_addr,
  input  logic [34:0]                   cfg_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [RULE_AWIDTH-1:0]        out_rule
`ifdef RULE_PORT_FILTER_STATS_EN
  ,
  input  logic                          stat_clr,
  output logic [31:0]                   stat_match,
  output logic [31:0]                   stat_nomatch,
  output logic [31:0]                   stat_zero
`endif
);

  localparam int unsigned TBL_DEPTH = 1 << PG_AWIDTH;
  localparam int unsigned PTR_W     = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W     = PTR_W + 1;

  // ROM-latency alignment stages
  logic [RULE_RD_LAT-1:0]   r_s_vld;
  logic [RULE_AWIDTH-1:0]   r_s_rule [RULE_RD_LAT];
  logic [15:0]              r_s_src  [RULE_RD_LAT];
  logic [15:0]              r_s_dst  [RULE_RD_LAT];
  logic                     r_s_tcp  [RULE_RD_LAT];

  // slot capture stage
  logic                     r_cap_vld;
  logic [RULE_AWIDTH-1:0]   r_cap_rule;
  logic [15:0]              r_cap_src;
  logic [15:0]              r_cap_dst;
  logic                     r_cap_tcp;
  logic [PG_AWIDTH-1:0]     r_cap_slot [NUM_PG];

  // range-table read stage
  logic                     r_rd_vld;
  logic [RULE_AWIDTH-1:0]   r_rd_rule;
  logic [15:0]              r_rd_src;
  logic [15:0]              r_rd_dst;
  logic                     r_rd_tcp;
  logic [NUM_PG-1:0]        r_rd_slot_v;
  logic [34:0]              r_rd_ent [NUM_PG];

  logic [34:0]              r_tbl [TBL_DEPTH];

  logic [RULE_AWIDTH-1:0]   r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]         r_wptr;
  logic [PTR_W-1:0]         r_rptr;
  logic [CNT_W-1:0]         r_cnt;
  logic [CNT_W-1:0]         r_inflight;

  logic                     w_acc;
  logic                     w_acc_rule;
  logic                     w_match;
  logic                     w_enq;
  logic                     w_deq;
  logic [CNT_W:0]           w_used;

  function automatic logic slot_hit(input logic [34:0] e, input logic [15:0] src,
                                    input logic [15:0] dst, input logic tcp);
    logic [15:0] port;
    logic        proto_ok;
    port = e[32] ? dst : src;
    case (e[34:33])
      2'd0:    proto_ok = 1'b1;
      2'd1:    proto_ok = tcp;
      2'd2:    proto_ok = ~tcp;
      default: proto_ok = 1'b0;
    endcase
    return proto_ok && (port >= e[31:16]) && (port <= e[15:0]);
  endfunction

  // Credits cover both buffered and in-flight beats, so the FIFO cannot overflow
  assign w_used     = (CNT_W+1)'(r_cnt) + (CNT_W+1)'(r_inflight);
  assign in_ready   = ~rst && (w_used < (CNT_W+1)'(FIFO_DEPTH));
  assign w_acc      = in_valid & in_ready;
  assign w_acc_rule = w_acc & (in_rule != '0);
  assign r2pg_addr  = in_rule - RULE_AWIDTH'(1);

  assign out_valid  = (r_cnt != '0);
  assign out_rule   = r_mem[r_rptr];
  assign w_deq      = out_valid & out_ready;
  assign w_enq      = r_rd_vld & w_match;

  always_comb begin
    w_match = 1'b0;
    for (int k = 0; k < NUM_PG; k++) begin
      if (r_rd_slot_v[k] && slot_hit(r_rd_ent[k], r_rd_src, r_rd_dst, r_rd_tcp)) begin
        w_match = 1'b1;
      end
    end
  end

  // Stage valids and bookkeeping, cleared by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s_vld    <= '0;
      r_cap_vld  <= 1'b0;
      r_rd_vld   <= 1'b0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_cnt      <= '0;
      r_inflight <= '0;
    end else begin
      r_s_vld[0] <= w_acc_rule;
      for (int i = 1; i < RULE_RD_LAT; i++) begin
        r_s_vld[i] <= r_s_vld[i-1];
      end
      r_cap_vld  <= r_s_vld[RULE_RD_LAT-1];
      r_rd_vld   <= r_cap_vld;
      r_inflight <= r_inflight + CNT_W'(w_acc_rule) - CNT_W'(r_rd_vld);
      r_cnt      <= r_cnt + CNT_W'(w_enq) - CNT_W'(w_deq);
      if (w_enq) r_wptr <= r_wptr + PTR_W'(1);
      if (w_deq) r_rptr <= r_rptr + PTR_W'(1);
    end
  end

  // Datapath payload, range table and FIFO storage; not reset
  always_ff @(posedge clk) begin
    r_s_rule[0] <= in_rule;
    r_s_src[0]  <= in_src_port;
    r_s_dst[0]  <= in_dst_port;
    r_s_tcp[0]  <= in_tcp;
    for (int i = 1; i < RULE_RD_LAT; i++) begin
      r_s_rule[i] <= r_s_rule[i-1];
      r_s_src[i]  <= r_s_src[i-1];
      r_s_dst[i]  <= r_s_dst[i-1];
      r_s_tcp[i]  <= r_s_tcp[i-1];
    end
    r_cap_rule <= r_s_rule[RULE_RD_LAT-1];
    r_cap_src  <= r_s_src[RULE_RD_LAT-1];
    r_cap_dst  <= r_s_dst[RULE_RD_LAT-1];
    r_cap_tcp  <= r_s_tcp[RULE_RD_LAT-1];
    for (int k = 0; k < NUM_PG; k++) begin
      r_cap_slot[k] <= r2pg_data[k*PG_AWIDTH +: PG_AWIDTH];
    end
    r_rd_rule <= r_cap_rule;
    r_rd_src  <= r_cap_src;
    r_rd_dst  <= r_cap_dst;
    r_rd_tcp  <= r_cap_tcp;
    // A same-cycle write to the read entry is seen only by later reads
    for (int k = 0; k < NUM_PG; k++) begin
      r_rd_slot_v[k] <= (r_cap_slot[k] != '0);
      r_rd_ent[k]    <= r_tbl[r_cap_slot[k]];
    end
    if (cfg_wr) r_tbl[cfg_addr] <= cfg_data;
    if (w_enq)  r_mem[r_wptr]   <= r_rd_rule;
  end

`ifdef RULE_PORT_FILTER_STATS_EN
  // Saturating event counters; clear has priority over increment
  always_ff @(posedge clk) begin
    if (rst || stat_clr) begin
      stat_match   <= '0;
      stat_nomatch <= '0;
      stat_zero    <= '0;
    end else begin
      if (r_rd_vld && w_match && (stat_match != '1))
        stat_match <= stat_match + 32'd1;
      if (r_rd_vld && !w_match && (stat_nomatch != '1))
        stat_nomatch <= stat_nomatch + 32'd1;
      if (w_acc && (in_rule == '0) && (stat_zero != '1))
        stat_zero <= stat_zero + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rule_port_filter.sv
// Randomised self-checking bench for rule_port_filter with a queue-based reference model.
module tb_rule_port_filter;

  localparam int unsigned RA  = 16;
  localparam int unsigned NPG = 4;
  localparam int unsigned PGA = 9;
  localparam int unsigned LAT = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [RA-1:0]   in_rule;
  logic [15:0]     in_src_port;
  logic [15:0]     in_dst_port;
  logic            in_tcp;
  logic [RA-1:0]   r2pg_addr;
  logic [NPG*PGA-1:0] r2pg_data;
  logic            cfg_wr;
  logic [PGA-1:0]  cfg_addr;
  logic [34:0]     cfg_data;
  logic            out_valid;
  logic            out_ready;
  logic [RA-1:0]   out_rule;
`ifdef RULE_PORT_FILTER_STATS_EN
  logic            stat_clr;
  logic [31:0]     stat_match;
  logic [31:0]     stat_nomatch;
  logic [31:0]     stat_zero;
`endif

  rule_port_filter dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_rule(in_rule),
    .in_src_port(in_src_port), .in_dst_port(in_dst_port), .in_tcp(in_tcp),
    .r2pg_addr(r2pg_addr), .r2pg_data(r2pg_data),
    .cfg_wr(cfg_wr), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_rule(out_rule)
`ifdef RULE_PORT_FILTER_STATS_EN
    , .stat_clr(stat_clr), .stat_match(stat_match),
    .stat_nomatch(stat_nomatch), .stat_zero(stat_zero)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int pops  = 0;
  int last_acc = 0;

  // Environment ROM with LAT-cycle read delay, and table mirror for the model
  logic [NPG*PGA-1:0] rom [256];
  logic [15:0]        ap  [LAT];
  logic [34:0]        m_tbl [512];
  int                 exp_q [$];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    ap[0] <= r2pg_addr;
    for (int i = 1; i < LAT; i++) ap[i] <= ap[i-1];
  end
  assign r2pg_data = rom[ap[LAT-1][7:0]];

  function automatic bit model_hit(int rule, int src, int dst, bit tcp);
    logic [NPG*PGA-1:0] slots;
    logic [34:0] e;
    int idx, port, proto, lo, hi;
    if (rule == 0) return 1'b0;
    slots = rom[rule-1];
    for (int k = 0; k < NPG; k++) begin
      idx = int'(slots[k*PGA +: PGA]);
      if (idx == 0) continue;
      e     = m_tbl[idx];
      proto = int'(e[34:33]);
      lo    = int'(e[31:16]);
      hi    = int'(e[15:0]);
      port  = e[32] ? dst : src;
      if (proto == 3) continue;
      if (proto == 1 && !tcp) continue;
      if (proto == 2 && tcp) continue;
      if (port >= lo && port <= hi) return 1'b1;
    end
    return 1'b0;
  endfunction

  // Output monitor: ordering against the model queue, and hold-while-stalled
  logic prev_hold = 1'b0;
  logic prev_rst  = 1'b1;
  logic [RA-1:0] prev_rule;
  always @(negedge clk) begin
    if (!rst && !prev_rst && prev_hold) begin
      total++;
      if (out_valid !== 1'b1 || out_rule !== prev_rule) begin
        bad++;
        $display("FAIL hold: out_valid=%0b out_rule=%0d required valid=1 rule=%0d", out_valid, out_rule, prev_rule);
      end
    end
    if (!rst && out_valid === 1'b1 && out_ready === 1'b1) begin
      total++;
      pops++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_out: got rule=%0d required none", out_rule);
      end else begin
        int e;
        e = exp_q.pop_front();
        if (out_rule !== RA'(e)) begin
          bad++;
          $display("FAIL out_order: got rule=%0d required %0d", out_rule, e);
        end
      end
    end
    prev_hold = (out_valid === 1'b1) && !out_ready && !rst;
    prev_rule = out_rule;
    prev_rst  = rst;
  end

  task automatic cfg_write(input int addr, input logic [34:0] data);
    cfg_wr = 1'b1; cfg_addr = PGA'(addr); cfg_data = data;
    @(posedge clk); #1;
    cfg_wr = 1'b0;
    m_tbl[addr] = data;
  endtask

  // Drive one beat until accepted; the model decision is queued at acceptance
  task automatic send(input int rule, input int src, input int dst, input bit tcp);
    bit ok = 1'b0;
    in_valid = 1'b1; in_rule = RA'(rule);
    in_src_port = 16'(src); in_dst_port = 16'(dst); in_tcp = tcp;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        last_acc = cyc;
        if (model_hit(rule, src, dst, tcp)) exp_q.push_back(rule);
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (!ok) begin
      total++; bad++;
      $display("FAIL send_timeout: rule=%0d never accepted", rule);
    end
  endtask

  task automatic drain();
    for (int n = 0; n < 500 && exp_q.size() != 0; n++) @(negedge clk);
    repeat (10) @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d outputs missing required 0", exp_q.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready: got %0b required 0", in_ready); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL post_reset_in_ready: got %0b required 1", in_ready); end
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %0b required 0", out_valid); end
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    bit seen = 1'b0;
    cfg_write(5, {2'd0, 1'b1, 16'd80, 16'd80});
    rom[6] = '0; rom[6][PGA-1:0] = PGA'(5);
    send(7, int'($urandom_range(0, 65535)), 80, 1'($urandom));
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (out_valid) begin seen = 1'b1; break; end
    end
    total++;
    if (!seen || (cyc - last_acc) != 5) begin
      bad++; $display("FAIL latency: seen=%0b got %0d cycles required 5", seen, cyc - last_acc);
    end
    total++;
    if (out_rule !== RA'(7)) begin bad++; $display("FAIL basic_rule: got %0d required 7", out_rule); end
    @(posedge clk); #1;
    drain();
  endtask

  task automatic test_nomatch();
    int p0 = pops;
    bit rdy_ok = 1'b1;
    send(7, 80, 81, 1'b1);
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (in_ready !== 1'b1) rdy_ok = 1'b0;
    end
    total++;
    if (!rdy_ok) begin bad++; $display("FAIL nomatch_ready: in_ready dropped required 1"); end
    total++;
    if (pops != p0) begin bad++; $display("FAIL nomatch_out: got %0d outputs required 0", pops - p0); end
    @(posedge clk); #1;
    drain();
  endtask

  task automatic test_proto();
    int p0;
    cfg_write(6, {2'd1, 1'b0, 16'd1000, 16'd2000});
    rom[8] = '0; rom[8][2*PGA-1:PGA] = PGA'(6);
    p0 = pops;
    send(9, 1500, int'($urandom_range(0, 65535)), 1'b1);
    send(9, 1500, int'($urandom_range(0, 65535)), 1'b0);
    drain();
    total++;
    if (pops - p0 != 1) begin bad++; $display("FAIL proto_tcp: got %0d outputs required 1", pops - p0); end
    cfg_write(6, {2'd3, 1'b0, 16'd1000, 16'd2000});
    p0 = pops;
    send(9, 1500, 0, 1'b1);
    send(9, 1500, 0, 1'b0);
    drain();
    total++;
    if (pops != p0) begin bad++; $display("FAIL proto_disabled: got %0d outputs required 0", pops - p0); end
  endtask

  task automatic test_back_to_back();
    int i = 0;
    for (int r = 10; r < 50; r++) begin rom[r-1] = '0; rom[r-1][PGA-1:0] = PGA'(5); end
    out_ready = 1'b0;
    for (int c = 0; c < 600 && i < 40; c++) begin
      in_valid = 1'b1; in_rule = RA'(10 + i); in_dst_port = 16'd80;
      in_src_port = 16'($urandom); in_tcp = 1'($urandom);
      @(negedge clk);
      if (c == 29) begin
        total++;
        if (in_ready !== 1'b0) begin bad++; $display("FAIL credit_stall: in_ready=%0b required 0", in_ready); end
        total++;
        if (i != 16) begin bad++; $display("FAIL credit_count: accepted %0d required 16", i); end
      end
      if (in_ready) begin
        if (model_hit(10 + i, int'(in_src_port), 80, in_tcp)) exp_q.push_back(10 + i);
        i++;
      end
      @(posedge clk); #1;
      if (c == 30) out_ready = 1'b1;
    end
    in_valid = 1'b0;
    total++;
    if (i != 40) begin bad++; $display("FAIL b2b_accept: accepted %0d required 40", i); end
    drain();
  endtask

  task automatic test_zero_rule();
    int zeros = 0, sevens = 0;
`ifdef RULE_PORT_FILTER_STATS_EN
    stat_clr = 1'b1; @(posedge clk); #1; stat_clr = 1'b0;
`endif
    for (int n = 0; n < 20; n++) begin
      if ($urandom_range(0, 1) == 0) begin zeros++; send(0, 80, 80, 1'b1); end
      else begin sevens++; send(7, int'($urandom_range(0, 65535)), 80, 1'($urandom)); end
    end
    drain();
`ifdef RULE_PORT_FILTER_STATS_EN
    total++;
    if (stat_zero !== 32'(zeros)) begin bad++; $display("FAIL stat_zero: got %0d required %0d", stat_zero, zeros); end
    total++;
    if (stat_match !== 32'(sevens)) begin bad++; $display("FAIL stat_match: got %0d required %0d", stat_match, sevens); end
    total++;
    if (stat_nomatch !== 32'd0) begin bad++; $display("FAIL stat_nomatch: got %0d required 0", stat_nomatch); end
`endif
  endtask

  task automatic test_reset_flush();
    int p0;
    out_ready = 1'b0;
    send(7, 1, 80, 1'b0);
    send(7, 2, 80, 1'b0);
    repeat (8) @(posedge clk);
    #1;
    send(7, 3, 80, 1'b1);
    send(7, 4, 80, 1'b1);
    send(7, 5, 80, 1'b1);
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_valid: got %0b required 0", out_valid); end
    p0 = pops;
    repeat (15) @(negedge clk);
    total++;
    if (pops != p0) begin bad++; $display("FAIL flush_out: got %0d outputs required 0", pops - p0); end
    @(posedge clk); #1;
    p0 = pops;
    send(7, 0, 80, 1'b0);
    drain();
    total++;
    if (pops - p0 != 1) begin bad++; $display("FAIL table_survive: got %0d outputs required 1", pops - p0); end
  endtask

  task automatic test_random();
    int src, dst, rule;
    bit tcp;
    for (int a = 1; a < 16; a++)
      cfg_write(a, {2'($urandom), 1'($urandom), 16'($urandom_range(0, 60)), 16'($urandom_range(0, 63))});
    for (int r = 100; r < 132; r++)
      for (int k = 0; k < NPG; k++) rom[r-1][k*PGA +: PGA] = PGA'($urandom_range(0, 15));
    for (int c = 0; c < 400; c++) begin
      rule = ($urandom_range(0, 5) == 0) ? 0 : 100 + int'($urandom_range(0, 31));
      src = int'($urandom_range(0, 63)); dst = int'($urandom_range(0, 63)); tcp = 1'($urandom);
      in_valid = ($urandom_range(0, 3) != 0);
      in_rule = RA'(rule); in_src_port = 16'(src); in_dst_port = 16'(dst); in_tcp = tcp;
      out_ready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      if (in_valid && in_ready && model_hit(rule, src, dst, tcp)) exp_q.push_back(rule);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_rule = '0; in_src_port = '0; in_dst_port = '0; in_tcp = 1'b0;
    cfg_wr = 1'b0; cfg_addr = '0; cfg_data = '0; out_ready = 1'b1;
`ifdef RULE_PORT_FILTER_STATS_EN
    stat_clr = 1'b0;
`endif
    for (int i = 0; i < 256; i++) rom[i] = '0;
    for (int i = 0; i < LAT; i++) ap[i] = '0;
    @(posedge clk); #1;
    test_reset();
    for (int a = 0; a < 512; a++) cfg_write(a, {2'd3, 1'b0, 16'd0, 16'hFFFF});
    test_basic();
    test_nomatch();
    test_proto();
    test_back_to_back();
    test_zero_rule();
    test_reset_flush();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
